// File: rtl/fsm_burst_pkg.sv
// -----------------------------------------------------------------------------
// fsm_burst_pkg
// Shared types for the burst read controller:
//   state_t      - controller state encoding
//   strobes_t    - the four state-decoded strobes {rd, ds, err, busy}
//   decode_state - Moore decode of a state into its strobes
// -----------------------------------------------------------------------------
package fsm_burst_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DELAY = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    typedef struct packed {
        logic rd;
        logic ds;
        logic err;
        logic busy;
    } strobes_t;

    function automatic strobes_t decode_state(input state_t s);
        strobes_t o;
        o = '0;
        case (s)
            READ:    begin o.rd = 1'b1; o.busy = 1'b1; end
            DELAY:   begin o.rd = 1'b1; o.busy = 1'b1; end
            DONE:    begin o.ds = 1'b1; o.busy = 1'b1; end
            ERROR:   o.err = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fsm_burst_reg.sv
// -----------------------------------------------------------------------------
// fsm_burst_reg
// Burst read controller between a requesting master and a slow memory port.
// One go request runs len+1 read beats; each beat retries while the memory
// asserts ws, up to WAIT_MAX retries, after which the controller enters ERROR.
// abort returns to IDLE from any busy or error state. All outputs are
// registered and decoded from the next state, so they line up with the
// state register and have no combinational path from the inputs.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   go       in   start request, sampled in IDLE
//   len      in   beats minus one, captured when go is accepted
//   ws       in   memory wait state, sampled in DELAY
//   abort    in   synchronous abort, highest priority outside IDLE
//   rd       out  read strobe (READ, DELAY)
//   ds       out  one-cycle done strobe (DONE)
//   err      out  timeout indication (ERROR)
//   busy     out  READ, DELAY or DONE
//   beat     out  current beat index
//   last     out  current beat is the final one (READ, DELAY)
// -----------------------------------------------------------------------------
module fsm_burst_reg
    import fsm_burst_pkg::*;
#(
    parameter int  BURST_W  = 4,
    parameter int  WAIT_MAX = 15,
    localparam int WCNT_W   = $clog2(WAIT_MAX + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               go,
    input  logic [BURST_W-1:0] len,
    input  logic               ws,
    input  logic               abort,
    output logic               rd,
    output logic               ds,
    output logic               err,
    output logic               busy,
    output logic [BURST_W-1:0] beat,
    output logic               last
);

    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);

    state_t             state_q, state_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    strobes_t           strb_q, strb_d;
    logic               last_q, last_d;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wcnt_d  = wcnt_q;

        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = READ;
                    len_d   = len;
                    beat_d  = '0;
                    wcnt_d  = '0;
                end
            end
            READ: state_d = DELAY;
            DELAY: begin
                if (ws) begin
                    // Retry the same beat until the retry budget is spent.
                    if (wcnt_q < WAIT_LIMIT) begin
                        state_d = READ;
                        wcnt_d  = wcnt_q + 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
                end else if (beat_q == len_q) begin
                    state_d = DONE;
                end else begin
                    // beat_q < len_q here, so the increment cannot wrap.
                    state_d = READ;
                    beat_d  = beat_q + 1'b1;
                    wcnt_d  = '0;
                end
            end
            DONE: state_d = IDLE;
            ERROR: begin
                if (!go) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // abort overrides every transition except from IDLE, where it is ignored.
        if (abort && (state_q != IDLE)) state_d = IDLE;

        // Outputs are decoded from the next state so the registered copies
        // always describe the state being entered.
        strb_d = decode_state(state_d);
        last_d = ((state_d == READ) || (state_d == DELAY)) && (beat_d == len_d);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            wcnt_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
        end
    end

    assign rd   = strb_q.rd;
    assign ds   = strb_q.ds;
    assign err  = strb_q.err;
    assign busy = strb_q.busy;
    assign beat = beat_q;
    assign last = last_q;

endmodule

// File: tb/tb_fsm_burst_reg.sv
module tb_fsm_burst_reg;

    localparam int BURST_W  = 4;
    localparam int WAIT_MAX = 15;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               go;
    logic [BURST_W-1:0] len;
    logic               ws;
    logic               abort;
    logic               rd, ds, err, busy, last;
    logic [BURST_W-1:0] beat;

    int checks   = 0;
    int failures = 0;

    fsm_burst_reg #(.BURST_W(BURST_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .go     (go),
        .len    (len),
        .ws     (ws),
        .abort  (abort),
        .rd     (rd),
        .ds     (ds),
        .err    (err),
        .busy   (busy),
        .beat   (beat),
        .last   (last)
    );

    always #5 clock = ~clock;

    // Observable outputs; beat is only meaningful while reading.
    typedef struct packed {
        logic               rd;
        logic               ds;
        logic               err;
        logic               busy;
        logic               last;
        logic [BURST_W-1:0] beat;
    } obs_t;

    obs_t exp_q[$];
    bit   ws_q[$];
    bit   ab_q[$];
    obs_t obs_q[$];
    int   plan[16];   // retries requested on each beat

    function automatic obs_t sample();
        obs_t o;
        o.rd   = rd;
        o.ds   = ds;
        o.err  = err;
        o.busy = busy;
        o.last = last;
        o.beat = rd ? beat : '0;
        return o;
    endfunction

    function automatic obs_t mk(input bit r, input bit d, input bit e, input bit b,
                                input bit l, input int bt);
        obs_t o;
        o.rd = r; o.ds = d; o.err = e; o.busy = b; o.last = l;
        o.beat = BURST_W'(bt);
        return o;
    endfunction

    // Expected per-cycle trace after go is accepted: each beat is one
    // READ/DELAY pair per attempt; more than WAIT_MAX retries ends in ERROR,
    // otherwise the burst ends with DONE then IDLE.
    function automatic void model_burst(input int L);
        bit timed_out;
        exp_q.delete(); ws_q.delete(); ab_q.delete();
        timed_out = 0;
        for (int b = 0; b <= L && !timed_out; b++) begin
            int attempts;
            attempts = (plan[b] > WAIT_MAX) ? WAIT_MAX + 1 : plan[b] + 1;
            for (int t = 0; t < attempts; t++) begin
                exp_q.push_back(mk(1, 0, 0, 1, b == L, b));
                ws_q.push_back(1'($urandom));
                ab_q.push_back(0);
                exp_q.push_back(mk(1, 0, 0, 1, b == L, b));
                ws_q.push_back(t < plan[b]);
                ab_q.push_back(0);
            end
            if (plan[b] > WAIT_MAX) timed_out = 1;
        end
        if (timed_out) begin
            exp_q.push_back(mk(0, 0, 1, 0, 0, 0)); ws_q.push_back(0); ab_q.push_back(0);
        end else begin
            exp_q.push_back(mk(0, 1, 0, 1, 0, 0)); ws_q.push_back(0); ab_q.push_back(0);
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0)); ws_q.push_back(0); ab_q.push_back(0);
        end
    endfunction

    // abort raised during entry idx: the following cycle is IDLE.
    function automatic void model_abort(input int idx);
        while (exp_q.size() > idx + 1) begin
            void'(exp_q.pop_back()); void'(ws_q.pop_back()); void'(ab_q.pop_back());
        end
        ab_q[idx] = 1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0)); ws_q.push_back(0); ab_q.push_back(0);
    endfunction

    function automatic void clear_plan();
        foreach (plan[k]) plan[k] = 0;
    endfunction

    // Issue go with len L, then replay the trace's ws/abort and record outputs.
    // go is raised again during entry go_idx (if any) to probe go handling.
    task automatic play(input int L, input int go_idx);
        obs_q.delete();
        @(negedge clock);
        go = 1; len = BURST_W'(L); ws = 0; abort = 0;
        @(posedge clock);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            if (i == 0) len = BURST_W'($urandom);
            go = (i == go_idx);
            obs_q.push_back(sample());
            ws    = ws_q[i];
            abort = ab_q[i];
            @(posedge clock);
        end
        @(negedge clock);
        ws = 0; abort = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; go = 0; len = '0; ws = 0; abort = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (rd   !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", rd); end
        checks++; if (ds   !== 1'b0) begin failures++; $display("FAIL reset_ds got=%b exp=0", ds); end
        checks++; if (err  !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", last); end
        checks++; if (beat !== '0)   begin failures++; $display("FAIL reset_beat got=%0d exp=0", beat); end
        reset_n = 1;
    endtask

    task automatic test_single();
        clear_plan();
        model_burst(0);
        play(0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_burst4();
        clear_plan();
        model_burst(3);
        play(3, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL burst4[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_retry();
        clear_plan();
        plan[0] = 1;
        model_burst(1);
        play(1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL retry[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        clear_plan();
        plan[0] = WAIT_MAX + 1;
        model_burst(0);
        // go is raised in the ERROR cycle and held to keep the block there.
        play(0, exp_q.size() - 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL timeout[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        go = 1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({err, rd, busy, ds} !== 4'b1000) begin
                failures++;
                $display("FAIL err_hold[%0d] got=%b exp=1000", k, {err, rd, busy, ds});
            end
            @(posedge clock); @(negedge clock);
        end
        go = 0;
        @(posedge clock); @(negedge clock);
        checks++;
        if ({err, rd, busy, ds} !== 4'b0000) begin
            failures++;
            $display("FAIL err_exit got=%b exp=0000", {err, rd, busy, ds});
        end
    endtask

    task automatic test_abort();
        clear_plan();
        model_burst(7);
        model_abort(5);   // DELAY of beat 2
        play(7, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL abort[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        model_burst(0);
        play(0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL after_abort[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        go = 1; len = 4'd5; ws = 0; abort = 0;
        @(posedge clock);
        @(negedge clock);
        go = 0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
        reset_n = 0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1;
        checks++;
        if ({rd, ds, err, busy, last, beat} !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=0", {rd, ds, err, busy, last, beat});
        end
        @(posedge clock); @(negedge clock);
        checks++;
        if ({rd, ds, err, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_idle got=%b exp=0000", {rd, ds, err, busy});
        end
    endtask

    task automatic test_done_go();
        clear_plan();
        model_burst(2);
        play(2, exp_q.size() - 2);   // go high while in DONE
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL done_go[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({rd, busy} !== 2'b00) begin
            failures++;
            $display("FAIL done_go_idle got=%b exp=00", {rd, busy});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int L;
            L = $urandom_range(0, 15);
            clear_plan();
            for (int b = 0; b <= L; b++)
                if ($urandom_range(0, 5) == 0) plan[b] = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) plan[$urandom_range(0, L)] = WAIT_MAX + 1;
            model_burst(L);
            if ($urandom_range(0, 3) == 0) model_abort($urandom_range(0, exp_q.size() - 2));
            play(L, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random%0d[%0d] got=%h exp=%h", n, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst4();
        test_retry();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_done_go();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
